// File: rtl/bcd_seq_converter.sv
//==============================================================================
// Module      : bcd_seq_converter
// Description : Sequential shift-and-add-3 binary-to-BCD converter, one bit
//               per clock, with registered digit outputs and busy/done status.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module bcd_seq_converter #(
    parameter int IN_W = 16,
    parameter int NDIG = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [IN_W-1:0]     number,
    output logic [4*NDIG-1:0]   digits_flat,
    output logic [3:0]          num_digits,
    output logic                busy,
    output logic                done
);

    // Smallest digit count able to hold 2^w-1.
    function automatic int f_min_digits(input int w);
        longint unsigned v;
        int              d;
        v = (w >= 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
        d = 1;
        for (int i = 0; i < 20; i++) begin
            if (v >= 64'd10) begin
                v = v / 64'd10;
                d = d + 1;
            end
        end
        return d;
    endfunction

    localparam int c_cnt_w   = $clog2(IN_W + 1);
    localparam int c_min_dig = f_min_digits(IN_W);

    if ((NDIG > 15) || (NDIG < c_min_dig)) begin : g_param_check
        $error("bcd_seq_converter: NDIG=%0d invalid for IN_W=%0d", NDIG, IN_W);
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nx;
    logic [IN_W-1:0]      r_last_num, w_last_num_nx;
    logic [IN_W-1:0]      r_sreg,     w_sreg_nx;
    logic [4*NDIG-1:0]    r_scratch,  w_scratch_nx;
    logic [c_cnt_w-1:0]   r_cnt,      w_cnt_nx;
    logic [4*NDIG-1:0]    r_digits,   w_digits_nx;
    logic [3:0]           r_ndig,     w_ndig_nx;
    logic                 r_busy,     w_busy_nx;
    logic                 r_done,     w_done_nx;
    logic [4*NDIG-1:0]    w_adj;
    logic [3:0]           w_ndig;

    // Each nibble is at most 9 before adjust, so +3 stays within the nibble.
    for (genvar k = 0; k < NDIG; k++) begin : g_adj
        assign w_adj[4*k +: 4] = (r_scratch[4*k +: 4] >= 4'd5) ?
                                 (r_scratch[4*k +: 4] + 4'd3) : r_scratch[4*k +: 4];
    end

    always_comb begin
        w_ndig = 4'd1;
        for (int k = 0; k < NDIG; k++) begin
            if (r_scratch[4*k +: 4] != 4'd0) begin
                w_ndig = 4'(k + 1);
            end
        end
    end

    always_comb begin
        w_state_nx    = r_state;
        w_last_num_nx = r_last_num;
        w_sreg_nx     = r_sreg;
        w_scratch_nx  = r_scratch;
        w_cnt_nx      = r_cnt;
        w_digits_nx   = r_digits;
        w_ndig_nx     = r_ndig;
        w_busy_nx     = r_busy;
        w_done_nx     = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_busy_nx = 1'b0;
                if (number != r_last_num) begin
                    w_sreg_nx     = number;
                    w_last_num_nx = number;
                    w_scratch_nx  = '0;
                    w_cnt_nx      = c_cnt_w'(IN_W);
                    w_busy_nx     = 1'b1;
                    w_state_nx    = S_SHIFT;
                end
            end
            S_SHIFT: begin
                w_scratch_nx = {w_adj[4*NDIG-2:0], r_sreg[IN_W-1]};
                w_sreg_nx    = {r_sreg[IN_W-2:0], 1'b0};
                w_cnt_nx     = r_cnt - c_cnt_w'(1);
                if (r_cnt == c_cnt_w'(1)) begin
                    w_state_nx = S_DONE;
                end
            end
            S_DONE: begin
                w_digits_nx = r_scratch;
                w_ndig_nx   = w_ndig;
                w_done_nx   = 1'b1;
                w_busy_nx   = 1'b0;
                w_state_nx  = S_IDLE;
            end
            default: begin
                w_busy_nx  = 1'b0;
                w_state_nx = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_last_num <= '0;
            r_sreg     <= '0;
            r_scratch  <= '0;
            r_cnt      <= '0;
            r_digits   <= '0;
            r_ndig     <= 4'd1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_last_num <= w_last_num_nx;
            r_sreg     <= w_sreg_nx;
            r_scratch  <= w_scratch_nx;
            r_cnt      <= w_cnt_nx;
            r_digits   <= w_digits_nx;
            r_ndig     <= w_ndig_nx;
            r_busy     <= w_busy_nx;
            r_done     <= w_done_nx;
        end
    end

    assign digits_flat = r_digits;
    assign num_digits  = r_ndig;
    assign busy        = r_busy;
    assign done        = r_done;

endmodule

`default_nettype wire

// File: tb/tb_bcd_seq_converter.sv
//==============================================================================
// Module      : tb_bcd_seq_converter
// Description : Scoreboard bench for bcd_seq_converter (IN_W=16, NDIG=8).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_bcd_seq_converter;

    logic        clk;
    logic        reset;
    logic [15:0] number;
    logic [31:0] digits_flat;
    logic [3:0]  num_digits;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;

    logic [35:0] sb_q[$];
    logic [31:0] prev_digits = 32'h0;

    bcd_seq_converter #(.IN_W(16), .NDIG(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .number      (number),
        .digits_flat (digits_flat),
        .num_digits  (num_digits),
        .busy        (busy),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every done pulse, and flags any
    // change of digits_flat that is not accompanied by done.
    always @(negedge clk) begin
        if (!reset) begin
            prev_digits = digits_flat;
        end else begin
            if (done) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done actual=%h required=none", digits_flat);
                end else begin
                    logic [35:0] e;
                    e = sb_q.pop_front();
                    chk("digits_flat", digits_flat, e[35:4]);
                    chk("num_digits", {28'h0, num_digits}, {28'h0, e[3:0]});
                end
            end
            if (digits_flat !== prev_digits) begin
                chk("digits_change_with_done", {31'h0, done}, 32'h1);
            end
            prev_digits = digits_flat;
        end
    end

    task automatic run_conv(input logic [15:0] v, input logic [31:0] d, input logic [3:0] n);
        @(posedge clk); #1;
        number = v;
        sb_q.push_back({d, n});
        @(posedge clk); #1;
        chk("busy_after_load", {31'h0, busy}, 32'h1);
        repeat (17) @(posedge clk);
        #1;
        chk("done_latency", {31'h0, done}, 32'h1);
        @(posedge clk); #1;
        chk("done_single", {31'h0, done}, 32'h0);
        chk("busy_idle", {31'h0, busy}, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset  = 1'b0;
        number = 16'd0;
        #12;
        chk("rst_digits", digits_flat, 32'h0);
        chk("rst_ndig", {28'h0, num_digits}, 32'h1);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_done", {31'h0, done}, 32'h0);
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        chk("zero_no_busy", {31'h0, busy}, 32'h0);

        run_conv(16'd999,  32'h00000999, 4'd3);
        run_conv(16'hFFFF, 32'h00065535, 4'd5);
        run_conv(16'd10,   32'h00000010, 4'd2);
        run_conv(16'd1000, 32'h00001000, 4'd4);

        // Change while busy: 456 waits until the first IDLE edge after DONE.
        @(posedge clk); #1;
        number = 16'd123;
        sb_q.push_back({32'h00000123, 4'd3});
        @(posedge clk); #1;
        chk("busy_123", {31'h0, busy}, 32'h1);
        repeat (5) @(posedge clk);
        #1;
        number = 16'd456;
        sb_q.push_back({32'h00000456, 4'd3});
        repeat (12) @(posedge clk);
        #1;
        chk("done_123", {31'h0, done}, 32'h1);
        @(posedge clk); #1;
        chk("done_123_clear", {31'h0, done}, 32'h0);
        chk("busy_reload_456", {31'h0, busy}, 32'h1);
        repeat (17) @(posedge clk);
        #1;
        chk("done_456", {31'h0, done}, 32'h1);
        @(posedge clk); #1;
        chk("busy_after_456", {31'h0, busy}, 32'h0);

        // Asynchronous reset in the middle of a conversion.
        @(posedge clk); #1;
        number = 16'd789;
        repeat (6) @(posedge clk);
        #3;
        reset  = 1'b0;
        number = 16'd0;
        #1;
        chk("midrst_digits", digits_flat, 32'h0);
        chk("midrst_ndig", {28'h0, num_digits}, 32'h1);
        chk("midrst_busy", {31'h0, busy}, 32'h0);
        chk("midrst_done", {31'h0, done}, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        run_conv(16'd42, 32'h00000042, 4'd2);

        run_conv(16'd777, 32'h00000777, 4'd3);
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            chk("hold_busy", {31'h0, busy}, 32'h0);
            chk("hold_done", {31'h0, done}, 32'h0);
        end

        for (int i = 0; i < 100 && sb_q.size() != 0; i++) @(posedge clk);
        @(negedge clk); #1;
        chk("scoreboard_drained", sb_q.size(), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
